// File: rtl/retirement_serializer.sv
// Group FIFO between the commit stage and the trace encoder: stores one group of up to
// NRET commits per cycle and replays its valid lanes one record at a time.
module retirement_serializer #(
  parameter int unsigned NRET      = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned XLEN      = 64,
  parameter int unsigned INST_LEN  = 32,
  parameter int unsigned CAUSE_LEN = 5,
  parameter int unsigned PRIV_LEN  = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NRET-1:0]          valid_i,
  input  logic [NRET*XLEN-1:0]     pc_i,
  input  logic [NRET*INST_LEN-1:0] inst_data_i,
  input  logic [NRET-1:0]          compressed_i,
  input  logic                     exception_i,
  input  logic                     interrupt_i,
  input  logic                     eret_i,
  input  logic [CAUSE_LEN-1:0]     cause_i,
  input  logic [XLEN-1:0]          tval_i,
  input  logic [PRIV_LEN-1:0]      priv_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [1:0]               iretire_o,
  output logic                     ilastsize_o,
  output logic [2:0]               itype_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic [XLEN-1:0]          iaddr_o,
  output logic                     overflow_o
);

  localparam int unsigned LW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NRET-1:0]      mem_mask  [DEPTH];
  logic [NRET-1:0]      mem_rvc   [DEPTH];
  logic [NRET*XLEN-1:0] mem_pc    [DEPTH];
  logic                 mem_exc   [DEPTH];
  logic                 mem_irq   [DEPTH];
  logic                 mem_eret  [DEPTH];
  logic [CAUSE_LEN-1:0] mem_cause [DEPTH];
  logic [XLEN-1:0]      mem_tval  [DEPTH];
  logic [PRIV_LEN-1:0]  mem_priv  [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [LW-1:0] lane_ptr;
  logic          overflow;

  logic [NRET-1:0] head_mask, head_rvc, refill_mask;
  logic [LW-1:0]   next_lane, refill_lane;
  logic            not_empty, has_higher, xfer, pop, push_req, push_acc, cur_valid;
  logic            unused_inst;

  assign unused_inst = ^inst_data_i;

  function automatic logic [LW-1:0] first_lane(input logic [NRET-1:0] m);
    first_lane = '0;
    for (int unsigned i = 0; i < NRET; i++)
      if (m[LW'(NRET-1-i)]) first_lane = LW'(NRET-1-i);
  endfunction

  always_comb begin
    head_mask  = mem_mask[rd_ptr];
    head_rvc   = mem_rvc[rd_ptr];
    not_empty  = (count != '0);
    has_higher = 1'b0;
    next_lane  = lane_ptr;
    for (int unsigned i = 0; i < NRET; i++) begin
      if (!has_higher && head_mask[LW'(i)] && (i > 32'(lane_ptr))) begin
        has_higher = 1'b1;
        next_lane  = LW'(i);
      end
    end
    xfer     = not_empty && ready_i;
    pop      = xfer && !has_higher;
    push_req = (|valid_i) || exception_i || eret_i;
    push_acc = push_req && ((count != CW'(DEPTH)) || pop);
    // The group after the head is the one being written this cycle when only one is stored.
    refill_mask = (count > CW'(1)) ? mem_mask[rd_ptr + PW'(1)] : valid_i;
    refill_lane = first_lane(pop ? refill_mask : valid_i);
    cur_valid   = head_mask[lane_ptr];
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem_mask[wr_ptr]  <= valid_i;
      mem_rvc[wr_ptr]   <= compressed_i;
      mem_pc[wr_ptr]    <= pc_i;
      mem_exc[wr_ptr]   <= exception_i;
      mem_irq[wr_ptr]   <= interrupt_i;
      mem_eret[wr_ptr]  <= eret_i;
      mem_cause[wr_ptr] <= cause_i;
      mem_tval[wr_ptr]  <= tval_i;
      mem_priv[wr_ptr]  <= priv_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      lane_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_req && !push_acc) overflow <= 1'b1;
      if (push_acc && !pop) count <= count + CW'(1);
      else if (!push_acc && pop) count <= count - CW'(1);
      if (xfer && has_higher) lane_ptr <= next_lane;
      else if (pop || (!not_empty && push_acc)) lane_ptr <= refill_lane;
    end
  end

  always_comb begin
    valid_o     = 1'b0;
    iretire_o   = '0;
    ilastsize_o = 1'b0;
    itype_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    iaddr_o     = '0;
    overflow_o  = overflow;
    if (not_empty) begin
      valid_o = 1'b1;
      cause_o = mem_cause[rd_ptr];
      tval_o  = mem_tval[rd_ptr];
      priv_o  = mem_priv[rd_ptr];
      if (cur_valid) begin
        iretire_o   = head_rvc[lane_ptr] ? 2'd1 : 2'd2;
        ilastsize_o = !head_rvc[lane_ptr];
        iaddr_o     = XLEN'(mem_pc[rd_ptr] >> (32'(lane_ptr) * XLEN));
      end
      if (!has_higher) begin
        if (mem_irq[rd_ptr])       itype_o = 3'd2;
        else if (mem_exc[rd_ptr])  itype_o = 3'd1;
        else if (mem_eret[rd_ptr]) itype_o = 3'd3;
      end
    end
  end

endmodule

// File: tb/tb_retirement_serializer.sv
// Randomized and directed bench for retirement_serializer against a record-queue model.
module tb_retirement_serializer;
  localparam int unsigned NRET      = 2;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned INST_LEN  = 32;
  localparam int unsigned CAUSE_LEN = 5;
  localparam int unsigned PRIV_LEN  = 2;
  localparam int unsigned OW        = 143;
  localparam int unsigned ILAST_BIT = 138;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NRET-1:0]          valid_i, compressed_i;
  logic [NRET*XLEN-1:0]     pc_i;
  logic [NRET*INST_LEN-1:0] inst_data_i;
  logic                     exception_i, interrupt_i, eret_i, ready;
  logic [CAUSE_LEN-1:0]     cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;
  logic                     valid_o, ilastsize_o, overflow_o;
  logic [1:0]               iretire_o;
  logic [2:0]               itype_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o, iaddr_o;
  logic [PRIV_LEN-1:0]      priv_o;

  retirement_serializer #(
    .NRET(NRET), .DEPTH(DEPTH), .XLEN(XLEN), .INST_LEN(INST_LEN),
    .CAUSE_LEN(CAUSE_LEN), .PRIV_LEN(PRIV_LEN)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .pc_i(pc_i), .inst_data_i(inst_data_i),
    .compressed_i(compressed_i), .exception_i(exception_i), .interrupt_i(interrupt_i),
    .eret_i(eret_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .ready_i(ready),
    .valid_o(valid_o), .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
    .overflow_o(overflow_o)
  );

  typedef struct {
    logic [1:0]  iretire;
    logic        ilast;
    logic [2:0]  itype;
    logic [4:0]  cause;
    logic [63:0] tval;
    logic [1:0]  priv;
    logic [63:0] iaddr;
    bit          last;
  } rec_t;

  rec_t mq[$];
  int   m_groups;
  bit   m_ovf;
  int   checks;
  int   failures;

  logic [OW-1:0] obs_raw;
  assign obs_raw = {valid_o, overflow_o, iretire_o, ilastsize_o, itype_o, cause_o,
                    tval_o, priv_o, iaddr_o};

  function automatic logic [OW-1:0] expv();
    if (mq.size() == 0) return {1'b0, m_ovf, 141'b0};
    return {1'b1, m_ovf, mq[0].iretire, mq[0].ilast, mq[0].itype, mq[0].cause,
            mq[0].tval, mq[0].priv, mq[0].iaddr};
  endfunction

  // Payload is don't-care when nothing is buffered; ilastsize is meaningless on event-only records.
  function automatic logic [OW-1:0] obsv();
    logic [OW-1:0] v;
    v = obs_raw;
    if (mq.size() == 0) v[140:0] = '0;
    else if (mq[0].iretire == 2'd0) v[ILAST_BIT] = 1'b0;
    return v;
  endfunction

  task automatic drive_idle();
    valid_i = '0; compressed_i = '0; pc_i = '0; inst_data_i = '0;
    exception_i = 1'b0; interrupt_i = 1'b0; eret_i = 1'b0;
    cause_i = '0; tval_i = '0; priv_i = '0;
  endtask

  task automatic drive_rand(input bit force_push);
    valid_i      = NRET'($urandom_range(0, 3));
    exception_i  = ($urandom_range(0, 5) == 0);
    interrupt_i  = exception_i && ($urandom_range(0, 1) == 1);
    eret_i       = !exception_i && ($urandom_range(0, 7) == 0);
    if (force_push && valid_i == '0 && !exception_i && !eret_i) valid_i = 2'b11;
    for (int unsigned l = 0; l < NRET; l++) pc_i[l*XLEN +: XLEN] = {$urandom, $urandom} & ~64'h1;
    compressed_i = NRET'($urandom);
    inst_data_i  = {$urandom, $urandom};
    cause_i      = CAUSE_LEN'($urandom);
    tval_i       = {$urandom, $urandom};
    priv_i       = PRIV_LEN'($urandom);
  endtask

  task automatic drive_group(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                             input logic [1:0] rvc, input logic exc, input logic irq,
                             input logic [4:0] cause);
    drive_idle();
    valid_i = v; pc_i = {pc1, pc0}; compressed_i = rvc;
    exception_i = exc; interrupt_i = irq; cause_i = cause;
    tval_i = 64'hABCD; priv_i = 2'd3;
  endtask

  // Model of one clock edge, then move to just after it.
  task automatic advance();
    bit   xfer, pop, req, acc;
    int   hi;
    rec_t r;
    logic [2:0] evt;
    xfer = (mq.size() > 0) && ready;
    pop  = xfer && mq[0].last;
    if (rst) begin
      mq.delete(); m_groups = 0; m_ovf = 0;
    end else begin
      req = (valid_i != '0) || exception_i || eret_i;
      acc = req && (m_groups < int'(DEPTH) || pop);
      if (xfer) begin
        void'(mq.pop_front());
        if (pop) m_groups--;
      end
      if (req && !acc) m_ovf = 1;
      if (acc) begin
        evt = interrupt_i ? 3'd2 : exception_i ? 3'd1 : eret_i ? 3'd3 : 3'd0;
        r.cause = cause_i; r.tval = tval_i; r.priv = priv_i;
        hi = -1;
        for (int l = 0; l < int'(NRET); l++) if (valid_i[l]) hi = l;
        if (hi < 0) begin
          r.iretire = 2'd0; r.ilast = 1'b0; r.iaddr = '0; r.itype = evt; r.last = 1;
          mq.push_back(r);
        end else begin
          for (int l = 0; l < int'(NRET); l++) begin
            if (valid_i[l]) begin
              r.iretire = compressed_i[l] ? 2'd1 : 2'd2;
              r.ilast   = !compressed_i[l];
              r.iaddr   = pc_i[l*XLEN +: XLEN];
              r.itype   = (l == hi) ? evt : 3'd0;
              r.last    = (l == hi);
              mq.push_back(r);
            end
          end
        end
        m_groups++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; drive_idle();
    advance(); advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b1;
    do_reset();
    @(negedge clk);
    checks++;
    if (obs_raw !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", obs_raw);
    end
    checks++;
    if (obsv() !== expv()) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", obsv(), expv());
    end
    advance();
  endtask

  task automatic test_directed();
    ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive_group(2'b11, 64'h1000, 64'h1004, 2'b01, 1'b0, 1'b0, 5'd0);
        3: drive_group(2'b10, 64'h2000, 64'h2004, 2'b00, 1'b1, 1'b0, 5'd2);
        5: drive_group(2'b00, 64'h0, 64'h0, 2'b00, 1'b1, 1'b1, 5'd7);
        default: drive_idle();
      endcase
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL directed_model c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      if (c == 1) begin
        checks++;
        if ({valid_o, iaddr_o, iretire_o, ilastsize_o} !== {1'b1, 64'h1000, 2'd1, 1'b0}) begin
          failures++; $display("FAIL directed_lane0 got=%h/%0d/%0d exp=1000/1/0", iaddr_o, iretire_o, ilastsize_o);
        end
      end
      if (c == 2) begin
        checks++;
        if ({valid_o, iaddr_o, iretire_o, ilastsize_o} !== {1'b1, 64'h1004, 2'd2, 1'b1}) begin
          failures++; $display("FAIL directed_lane1 got=%h/%0d/%0d exp=1004/2/1", iaddr_o, iretire_o, ilastsize_o);
        end
      end
      if (c == 4) begin
        checks++;
        if ({valid_o, iaddr_o, itype_o, cause_o} !== {1'b1, 64'h2004, 3'd1, 5'd2}) begin
          failures++; $display("FAIL directed_exc got=%h/%0d/%0d exp=2004/1/2", iaddr_o, itype_o, cause_o);
        end
      end
      if (c == 6) begin
        checks++;
        if ({valid_o, itype_o, iretire_o, iaddr_o} !== {1'b1, 3'd2, 2'd0, 64'h0}) begin
          failures++; $display("FAIL directed_evt got=%0d/%0d/%h exp=2/0/0", itype_o, iretire_o, iaddr_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) drive_idle(); else drive_rand(1'b0);
      ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL random c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      advance();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive_rand(1'b1); valid_i = 2'b11;
      @(negedge clk);
      if (c == 16 || c == 17) begin
        checks++;
        if (overflow_o !== (c == 17)) begin
          failures++; $display("FAIL overflow_edge c=%0d got=%b exp=%b", c, overflow_o, c == 17);
        end
      end
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL overflow_fill c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      advance();
    end
    drive_idle(); ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL overflow_drain c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      advance();
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      ready = (c >= 16);
      if (c < 16 || c == 17) begin drive_rand(1'b1); valid_i = 2'b11; end
      else drive_idle();
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL full_pop c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      advance();
    end
    @(negedge clk);
    checks++;
    if (overflow_o !== 1'b0) begin
      failures++; $display("FAIL full_pop_ovf got=%b exp=0", overflow_o);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin drive_rand(1'b1); advance(); end
    rst = 1'b1; drive_rand(1'b1);
    advance();
    rst = 1'b0; drive_idle();
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_valid got=%b exp=0", valid_o);
    end
    advance();
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) drive_rand(1'b1); else drive_idle();
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        failures++; $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obsv(), expv());
      end
      advance();
    end
  endtask

  initial begin
    checks = 0; failures = 0; m_groups = 0; m_ovf = 0;
    rst = 1'b1; ready = 1'b0; drive_idle();
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_random();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
